apb_multi_slave: RTL and testbench

APB_MULTI_SLAVE -- requirements
Module: apb_multi_slave

---
 rtl/apb_multi_slave.sv | 171 +++++++++++++++++
 tb/tb_apb_multi_slave.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_multi_slave.sv
// APB master FSM plus NSLV register-bank slaves on a shared internal bus.
// A requester raises PTX with a command; the master runs SETUP/ACCESS on
// the internal APB bus and returns RDATA/ERR with a one-cycle DONE pulse.
//
// state  | meaning
// IDLE   | no transfer, PSEL/PENABLE low, ready to accept
// SETUP  | PSEL driven, PENABLE low, exactly one cycle
// ACCESS | PSEL and PENABLE high, waiting for PREADY
module apb_multi_slave #(
   parameter int AW    = 8,
   parameter int DW    = 32,
   parameter int NSLV  = 4,
   parameter int DEPTH = 16,
   parameter int WAIT  = 1
) (
   input  logic            PCLK,
   input  logic            PRESET,
   input  logic            PTX,
   input  logic            WRITE,
   input  logic [AW-1:0]   ADDR,
   input  logic [DW-1:0]   WDATA,
   input  logic [DW/8-1:0] WSTRB,
   output logic            ACC,
   output logic            BUSY,
   output logic            DONE,
   output logic [DW-1:0]   RDATA,
   output logic            ERR
);

   localparam int IW = $clog2(DEPTH);
   localparam int NB = DW / 8;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t          state;

   // internal APB bus; only the word index is routed, slave select is one-hot
   logic [NSLV-1:0] psel;
   logic            penable;
   logic            pwrite;
   logic [IW-1:0]   paddr;
   logic [DW-1:0]   pwdata;
   logic [NB-1:0]   pstrb;
   logic            pready;
   logic            pslverr;
   logic [DW-1:0]   prdata;
   logic            dec_err;

   logic [NSLV-1:0] sel_dec;
   logic            err_dec;

   logic [NSLV-1:0] slv_ready;
   logic [NSLV-1:0] slv_err;
   logic [NSLV-1:0] wr_en;
   logic [DW-1:0]   slv_rdata [NSLV];
   logic [3:0]      cnt       [NSLV];
   logic [DW-1:0]   mem       [NSLV][DEPTH];

   // Decode the requested slave index before it is latched
   always_comb begin
      sel_dec = '0;
      err_dec = (int'(ADDR[AW-1:IW]) >= NSLV);
      for (int s = 0; s < NSLV; s++) begin
         if (int'(ADDR[AW-1:IW]) == s) sel_dec[s] = 1'b1;
      end
   end

   assign ACC  = ~PRESET & PTX & ((state == IDLE) | ((state == ACCESS) & pready));
   assign BUSY = (state != IDLE);

   // Master FSM; bus controls and completion status are registered here
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state   <= IDLE;
         psel    <= '0;
         penable <= 1'b0;
         pwrite  <= 1'b0;
         paddr   <= '0;
         pwdata  <= '0;
         pstrb   <= '0;
         dec_err <= 1'b0;
         DONE    <= 1'b0;
         RDATA   <= '0;
         ERR     <= 1'b0;
      end else begin
         DONE <= 1'b0;
         if ((state == ACCESS) && pready) begin
            DONE  <= 1'b1;
            RDATA <= pwrite ? '0 : prdata;
            ERR   <= pslverr;
         end
         if (ACC) begin
            state   <= SETUP;
            psel    <= sel_dec;
            dec_err <= err_dec;
            penable <= 1'b0;
            pwrite  <= WRITE;
            paddr   <= ADDR[IW-1:0];
            pwdata  <= WDATA;
            pstrb   <= WSTRB;
         end else begin
            case (state)
               SETUP: begin
                  state   <= ACCESS;
                  penable <= 1'b1;
               end
               ACCESS: begin
                  if (pready) begin
                     state   <= IDLE;
                     psel    <= '0;
                     penable <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Return-path mux; an unmapped slave answers at once with an error
   always_comb begin
      pready  = dec_err;
      pslverr = dec_err;
      prdata  = '0;
      for (int s = 0; s < NSLV; s++) begin
         if (psel[s]) begin
            pready  = pready  | slv_ready[s];
            pslverr = pslverr | slv_err[s];
            prdata  = prdata  | slv_rdata[s];
         end
      end
   end

   for (genvar s = 0; s < NSLV; s++) begin : g_slv
      assign slv_ready[s] = (cnt[s] == 4'(WAIT));
      assign slv_err[s]   = pwrite & (paddr == '0);
      assign slv_rdata[s] = (paddr == '0) ? DW'(s) : mem[s][paddr];
      assign wr_en[s]     = psel[s] & penable & slv_ready[s] & pwrite & (paddr != '0);

      // Wait-state counter: runs only during ACCESS, clears on completion or deselect
      always_ff @(posedge PCLK) begin
         if (PRESET) begin
            cnt[s] <= '0;
         end else if (psel[s] && penable && !slv_ready[s]) begin
            cnt[s] <= cnt[s] + 4'd1;
         end else begin
            cnt[s] <= '0;
         end
      end
   end

   // Register storage; word 0 is never written (it reads as the slave index)
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         for (int s = 0; s < NSLV; s++) begin
            for (int w = 0; w < DEPTH; w++) begin
               mem[s][w] <= '0;
            end
         end
      end else begin
         for (int s = 0; s < NSLV; s++) begin
            if (wr_en[s]) begin
               for (int b = 0; b < NB; b++) begin
                  if (pstrb[b]) mem[s][paddr][b*8 +: 8] <= pwdata[b*8 +: 8];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_multi_slave.sv
// Directed bench: a default-parameter instance plus an NSLV=3 instance
// sharing the same request inputs, each checked against hand-computed values.
module tb_apb_multi_slave;

   logic        clk;
   logic        rst;
   logic        ptx;
   logic        write;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;

   logic        acc, busy, done, err;
   logic [31:0] rdata;
   logic        acc3, busy3, done3, err3;
   logic [31:0] rdata3;

   int vectors = 0;
   int errors  = 0;

   apb_multi_slave u_dut (
      .PCLK(clk), .PRESET(rst), .PTX(ptx), .WRITE(write), .ADDR(addr),
      .WDATA(wdata), .WSTRB(wstrb), .ACC(acc), .BUSY(busy), .DONE(done),
      .RDATA(rdata), .ERR(err)
   );

   apb_multi_slave #(.NSLV(3)) u_dut3 (
      .PCLK(clk), .PRESET(rst), .PTX(ptx), .WRITE(write), .ADDR(addr),
      .WDATA(wdata), .WSTRB(wstrb), .ACC(acc3), .BUSY(busy3), .DONE(done3),
      .RDATA(rdata3), .ERR(err3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One complete transfer on the default instance; lat = negedges after the accepting edge
   task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic er,
                       output int lat);
      @(negedge clk);
      ptx = 1'b1; write = w; addr = a; wdata = d; wstrb = s;
      @(posedge clk);
      lat = 99; rd = 32'h0; er = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) ptx = 1'b0;
         if (done === 1'b1) begin
            lat = k; rd = rdata; er = err;
            break;
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; ptx = 1'b1; write = 1'b0; addr = 8'h13; wdata = '0; wstrb = '0;
      repeat (3) @(negedge clk);
      #1;
      vectors++; if (acc !== 1'b0) begin errors++; $display("FAIL reset_acc got %b want 0", acc); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      vectors++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
      vectors++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
      ptx = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic;
      logic [31:0] rd; logic er; int lat;
      xfer(1'b1, 8'h13, 32'hDEADBEEF, 4'hF, rd, er, lat);
      vectors++; if (lat != 4) begin errors++; $display("FAIL basic_wr_lat got %0d want 4", lat); end
      vectors++; if (er !== 1'b0) begin errors++; $display("FAIL basic_wr_err got %b want 0", er); end
      vectors++; if (rd !== 32'h0) begin errors++; $display("FAIL basic_wr_rdata got %h want 0", rd); end
      vectors++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
      xfer(1'b0, 8'h13, 32'h0, 4'h0, rd, er, lat);
      vectors++; if (lat != 4) begin errors++; $display("FAIL basic_rd_lat got %0d want 4", lat); end
      vectors++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data got %h want deadbeef", rd); end
      vectors++; if (er !== 1'b0) begin errors++; $display("FAIL basic_rd_err got %b want 0", er); end
      vectors++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rdata_hold got %h want deadbeef", rdata); end
   endtask

   task automatic test_strobe;
      logic [31:0] rd; logic er; int lat;
      xfer(1'b1, 8'h25, 32'hFFFFFFFF, 4'hF, rd, er, lat);
      xfer(1'b1, 8'h25, 32'h00000000, 4'h5, rd, er, lat);
      xfer(1'b0, 8'h25, 32'h0, 4'h0, rd, er, lat);
      vectors++; if (rd !== 32'hFF00FF00) begin errors++; $display("FAIL strobe_rd got %h want ff00ff00", rd); end
      xfer(1'b1, 8'h25, 32'h12345678, 4'h0, rd, er, lat);
      vectors++; if (er !== 1'b0) begin errors++; $display("FAIL strobe_zero_err got %b want 0", er); end
      xfer(1'b0, 8'h25, 32'h0, 4'h0, rd, er, lat);
      vectors++; if (rd !== 32'hFF00FF00) begin errors++; $display("FAIL strobe_zero_rd got %h want ff00ff00", rd); end
   endtask

   task automatic test_ro_word;
      logic [31:0] rd; logic er; int lat;
      xfer(1'b0, 8'h30, 32'h0, 4'h0, rd, er, lat);
      vectors++; if (rd !== 32'h3) begin errors++; $display("FAIL ro_rd0 got %h want 3", rd); end
      vectors++; if (er !== 1'b0) begin errors++; $display("FAIL ro_rd0_err got %b want 0", er); end
      xfer(1'b1, 8'h30, 32'hA5A5A5A5, 4'hF, rd, er, lat);
      vectors++; if (er !== 1'b1) begin errors++; $display("FAIL ro_wr_err got %b want 1", er); end
      xfer(1'b0, 8'h30, 32'h0, 4'h0, rd, er, lat);
      vectors++; if (rd !== 32'h3) begin errors++; $display("FAIL ro_rd1 got %h want 3", rd); end
      xfer(1'b0, 8'h10, 32'h0, 4'h0, rd, er, lat);
      vectors++; if (rd !== 32'h1) begin errors++; $display("FAIL ro_slave1 got %h want 1", rd); end
   endtask

   task automatic test_independence;
      logic [31:0] rd; logic er; int lat;
      xfer(1'b1, 8'h23, 32'h12345678, 4'hF, rd, er, lat);
      xfer(1'b0, 8'h13, 32'h0, 4'h0, rd, er, lat);
      vectors++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL indep_s1 got %h want deadbeef", rd); end
      xfer(1'b0, 8'h33, 32'h0, 4'h0, rd, er, lat);
      vectors++; if (rd !== 32'h0) begin errors++; $display("FAIL indep_s3 got %h want 0", rd); end
      xfer(1'b0, 8'h23, 32'h0, 4'h0, rd, er, lat);
      vectors++; if (rd !== 32'h12345678) begin errors++; $display("FAIL indep_s2 got %h want 12345678", rd); end
   endtask

   task automatic test_decode_err;
      int lat; logic seen; logic [31:0] rd; logic er;
      lat = 99; seen = 1'b0; rd = 32'hX; er = 1'b0;
      @(negedge clk);
      ptx = 1'b1; write = 1'b0; addr = 8'h35; wdata = '0; wstrb = '0;
      @(posedge clk);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) ptx = 1'b0;
         if (|u_dut3.psel) seen = 1'b1;
         if (done3 === 1'b1) begin
            lat = k; rd = rdata3; er = err3;
            break;
         end
      end
      repeat (4) @(negedge clk);
      vectors++; if (lat != 3) begin errors++; $display("FAIL dec_lat got %0d want 3", lat); end
      vectors++; if (seen !== 1'b0) begin errors++; $display("FAIL dec_psel got %b want 0", seen); end
      vectors++; if (er !== 1'b1) begin errors++; $display("FAIL dec_err got %b want 1", er); end
      vectors++; if (rd !== 32'h0) begin errors++; $display("FAIL dec_rdata got %h want 0", rd); end
   endtask

   task automatic test_back_to_back;
      logic [7:0]  a_tab [3];
      logic [31:0] d_tab [3];
      int done_at [3];
      int idx, ndone, naccept, idle_gaps;
      logic adv;
      logic [31:0] rd; logic er; int lat;
      a_tab[0] = 8'h14; a_tab[1] = 8'h15; a_tab[2] = 8'h16;
      d_tab[0] = 32'h000000A1; d_tab[1] = 32'h000000B2; d_tab[2] = 32'h000000C3;
      idx = 0; ndone = 0; naccept = 0; idle_gaps = 0; adv = 1'b0;
      for (int i = 0; i < 3; i++) done_at[i] = -1;
      @(negedge clk);
      ptx = 1'b1; write = 1'b1; addr = a_tab[0]; wdata = d_tab[0]; wstrb = 4'hF;
      #1;
      adv = acc;
      if (acc === 1'b1) naccept++;
      for (int cyc = 1; cyc <= 40 && ndone < 3; cyc++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_at[ndone] = cyc;
            ndone++;
         end
         if (ndone < 3 && busy !== 1'b1) idle_gaps++;
         if (adv) begin
            idx++;
            if (idx >= 3) ptx = 1'b0;
            else begin addr = a_tab[idx]; wdata = d_tab[idx]; end
         end
         #1;
         adv = (ptx === 1'b1) && (acc === 1'b1);
         if (adv) naccept++;
      end
      ptx = 1'b0;
      repeat (6) @(negedge clk);
      vectors++; if (ndone != 3) begin errors++; $display("FAIL b2b_ndone got %0d want 3", ndone); end
      vectors++; if (naccept != 3) begin errors++; $display("FAIL b2b_naccept got %0d want 3", naccept); end
      vectors++; if (idle_gaps != 0) begin errors++; $display("FAIL b2b_idle got %0d want 0", idle_gaps); end
      vectors++; if (done_at[0] != 4) begin errors++; $display("FAIL b2b_first got %0d want 4", done_at[0]); end
      vectors++; if (done_at[1] - done_at[0] != 3) begin errors++; $display("FAIL b2b_gap1 got %0d want 3", done_at[1] - done_at[0]); end
      vectors++; if (done_at[2] - done_at[1] != 3) begin errors++; $display("FAIL b2b_gap2 got %0d want 3", done_at[2] - done_at[1]); end
      xfer(1'b0, 8'h15, 32'h0, 4'h0, rd, er, lat);
      vectors++; if (rd !== 32'hB2) begin errors++; $display("FAIL b2b_rd15 got %h want b2", rd); end
      xfer(1'b0, 8'h16, 32'h0, 4'h0, rd, er, lat);
      vectors++; if (rd !== 32'hC3) begin errors++; $display("FAIL b2b_rd16 got %h want c3", rd); end
   endtask

   task automatic test_reset_mid;
      int ndone;
      logic [31:0] rd; logic er; int lat;
      ndone = 0;
      @(negedge clk);
      ptx = 1'b1; write = 1'b1; addr = 8'h12; wdata = 32'hCAFEF00D; wstrb = 4'hF;
      @(posedge clk);
      @(negedge clk);
      ptx = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
      vectors++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", done); end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      vectors++; if (ndone != 0) begin errors++; $display("FAIL rstmid_late_done got %0d want 0", ndone); end
      xfer(1'b0, 8'h12, 32'h0, 4'h0, rd, er, lat);
      vectors++; if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_rd12 got %h want 0", rd); end
      xfer(1'b0, 8'h13, 32'h0, 4'h0, rd, er, lat);
      vectors++; if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_rd13 got %h want 0", rd); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_strobe;
      test_ro_word;
      test_independence;
      test_decode_err;
      test_back_to_back;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
